// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the two-port SRAM controller arbiter: FSM encoding,
// port indices and wait-counter sizing.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT0  = 2'd1,
        ST_GRANT1  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int PORT0       = 0;
    localparam int PORT1       = 1;
    localparam int TIMEOUT_DEF = 255;
    localparam int WAIT_W      = 8;

    function automatic logic is_grant(input arb_state_e s);
        return (s == ST_GRANT0) || (s == ST_GRANT1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter_2.sv
// Two-request picker: a lone requester always wins; on a tie the pointer
// (or port 0 when fixed priority is selected) decides.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       fixed_prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (fixed_prio_i || !ptr_i) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller between the MEM-stage port (0) and a secondary
// master (1). The granted command is latched and held until mem_ready.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_r_en,
    input  logic              p0_w_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_r_en,
    input  logic              p1_w_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_timeout
);

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              cmd_we_q, cmd_we_d;
    logic              ptr_q, ptr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    logic       p0_req, p1_req, in_grant;
    logic [1:0] gnt;

    assign p0_req   = p0_r_en | p0_w_en;
    assign p1_req   = p1_r_en | p1_w_en;
    assign in_grant = is_grant(state_q);

    rr_arbiter_2 u_pick (
        .req_i        ({p1_req, p0_req}),
        .ptr_i        (ptr_q),
        .fixed_prio_i (FIXED_PRIO != 0),
        .gnt_o        (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_we_q    <= 1'b0;
            ptr_q       <= 1'b0;
            wait_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_we_q    <= cmd_we_d;
            ptr_q       <= ptr_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_we_d    = cmd_we_q;
        ptr_d       = ptr_q;
        wait_d      = wait_q;
        err_d       = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    // A port asserting both enables is served as a write.
                    state_d     = gnt[PORT1] ? ST_GRANT1 : ST_GRANT0;
                    cmd_addr_d  = gnt[PORT1] ? p1_addr  : p0_addr;
                    cmd_wdata_d = gnt[PORT1] ? p1_wdata : p0_wdata;
                    cmd_we_d    = gnt[PORT1] ? p1_w_en  : p0_w_en;
                    wait_d      = '0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (wait_q == TIMEOUT_V) err_d = 1'b1;
                if (mem_ready) begin
                    state_d = ST_RELEASE;
                    ptr_d   = (state_q == ST_GRANT0);
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign mem_read_en  = in_grant & ~cmd_we_q;
    assign mem_write_en = in_grant &  cmd_we_q;
    assign mem_addr     = cmd_addr_q;
    assign mem_wdata    = cmd_wdata_q;
    assign err_timeout  = err_q;

    // A port that is not requesting always sees ready, so a dropped request stalls nobody.
    assign p0_ready = ~p0_req | ((state_q == ST_GRANT0) & mem_ready);
    assign p1_ready = ~p1_req | ((state_q == ST_GRANT1) & mem_ready);
    assign p0_rdata = (state_q == ST_GRANT0) ? mem_rdata : '0;
    assign p1_rdata = (state_q == ST_GRANT1) ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: tests push expected completions; a monitor checks each
// completion the arbiter presents to the SRAM controller.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        p0_r_en, p0_w_en, p1_r_en, p1_w_en, p0_ready, p1_ready;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, p0_rdata, p1_rdata;
    logic        mem_read_en, mem_write_en, mem_ready, err_timeout;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_p0_r_en, b_p0_w_en, b_p1_r_en, b_p1_w_en, b_p0_ready, b_p1_ready;
    logic [31:0] b_p0_addr, b_p0_wdata, b_p1_addr, b_p1_wdata, b_p0_rdata, b_p1_rdata;
    logic        b_mem_read_en, b_mem_write_en, b_mem_ready, b_err_timeout;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    assign mem_rdata   = model(mem_addr);
    assign b_mem_rdata = model(b_mem_addr);
    assign b_mem_ready = b_mem_read_en | b_mem_write_en;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .p0_r_en(p0_r_en), .p0_w_en(p0_w_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_r_en(p1_r_en), .p1_w_en(p1_w_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .err_timeout(err_timeout)
    );

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(255)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_r_en(b_p0_r_en), .p0_w_en(b_p0_w_en), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_ready(b_p0_ready), .p0_rdata(b_p0_rdata),
        .p1_r_en(b_p1_r_en), .p1_w_en(b_p1_w_en), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_ready(b_p1_ready), .p1_rdata(b_p1_rdata),
        .mem_read_en(b_mem_read_en), .mem_write_en(b_mem_write_en), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata),
        .err_timeout(b_err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // SRAM controller model: ready after lat cycles of a held enable.
    int lat = 0;
    bit hold_ready = 1'b0;
    int wcnt = 0;
    always @(posedge clk) begin
        #1;
        if ((mem_read_en || mem_write_en) && !hold_ready) begin
            if (wcnt == lat) begin mem_ready = 1'b1; wcnt = 0; end
            else begin mem_ready = 1'b0; wcnt++; end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    function automatic exp_t mk(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.port = p; e.we = we; e.addr = a; e.wdata = d;
        e.rdata = we ? 32'h0 : model(a);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && mem_ready && (mem_read_en || mem_write_en)) begin
            int port;
            exp_t e;
            port = ((p0_r_en | p0_w_en) && p0_ready) ? 0 :
                   ((p1_r_en | p1_w_en) && p1_ready) ? 1 : -1;
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", 32'(port), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("grant_port", 32'(port), 32'(e.port));
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_write_en", 32'(mem_write_en), 32'(e.we));
                if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                else chk("rdata", (e.port == 0) ? p0_rdata : p1_rdata, e.rdata);
                if (e.port == 0) begin
                    if (p1_r_en | p1_w_en) chk("p1_ready_blocked", 32'(p1_ready), 32'd0);
                    chk("p1_rdata_zero", p1_rdata, 32'h0);
                end else begin
                    if (p0_r_en | p0_w_en) chk("p0_ready_blocked", 32'(p0_ready), 32'd0);
                    chk("p0_rdata_zero", p0_rdata, 32'h0);
                end
            end
        end
    end

    task automatic access(input int p, input bit we, input bit both,
                          input logic [31:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #2;
        if (p == 0) begin p0_r_en = !we | both; p0_w_en = we; p0_addr = a; p0_wdata = d; end
        else        begin p1_r_en = !we | both; p1_w_en = we; p1_addr = a; p1_wdata = d; end
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if ((p == 0) ? p0_ready : p1_ready) break;
        end
        if (n == 60) chk($sformatf("p%0d_ready_timeout", p), 32'd0, 32'd1);
        @(posedge clk); #2;
        if (p == 0) begin p0_r_en = 1'b0; p0_w_en = 1'b0; end
        else        begin p1_r_en = 1'b0; p1_w_en = 1'b0; end
    endtask

    initial begin
        int cnt;
        int n;
        rst = 1'b1; mem_ready = 1'b0;
        {p0_r_en, p0_w_en, p1_r_en, p1_w_en} = '0;
        {p0_addr, p0_wdata, p1_addr, p1_wdata} = '0;
        {b_p0_r_en, b_p0_w_en, b_p1_r_en, b_p1_w_en} = '0;
        {b_p0_addr, b_p0_wdata, b_p1_addr, b_p1_wdata} = '0;
        repeat (2) @(negedge clk);
        chk("rst_read_en", 32'(mem_read_en), 32'd0);
        chk("rst_write_en", 32'(mem_write_en), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_p0_ready", 32'(p0_ready), 32'd1);
        rst = 1'b0;

        // Simultaneous writes after reset: pointer at port 0.
        lat = 1;
        exp_q.push_back(mk(0, 1, 32'h10, 32'h1111_1111));
        exp_q.push_back(mk(1, 1, 32'h20, 32'h2222_2222));
        fork
            access(0, 1, 0, 32'h10, 32'h1111_1111);
            access(1, 1, 0, 32'h20, 32'h2222_2222);
        join

        // Single read, enable one cycle after request, ready after 3 wait cycles.
        lat = 3;
        exp_q.push_back(mk(0, 0, 32'h100, 32'h0));
        fork
            access(0, 0, 0, 32'h100, 32'h0);
            begin
                @(posedge clk); #3;
                @(negedge clk);
                chk("lat_idle_read_en", 32'(mem_read_en), 32'd0);
                @(negedge clk);
                chk("lat_grant_read_en", 32'(mem_read_en), 32'd1);
                chk("lat_grant_addr", mem_addr, 32'h100);
            end
        join

        // Port 0 was served last, so port 1 wins this tie.
        lat = 0;
        exp_q.push_back(mk(1, 1, 32'h24, 32'h3333_3333));
        exp_q.push_back(mk(0, 1, 32'h14, 32'h4444_4444));
        fork
            access(0, 1, 0, 32'h14, 32'h4444_4444);
            access(1, 1, 0, 32'h24, 32'h3333_3333);
        join

        // Back-to-back contention alternates ports.
        lat = 2;
        exp_q.push_back(mk(1, 0, 32'h300, 32'h0));
        exp_q.push_back(mk(0, 1, 32'h30, 32'h5555_5555));
        exp_q.push_back(mk(1, 1, 32'h310, 32'h6666_6666));
        exp_q.push_back(mk(0, 0, 32'h40, 32'h0));
        fork
            begin access(0, 1, 0, 32'h30, 32'h5555_5555); access(0, 0, 0, 32'h40, 32'h0); end
            begin access(1, 0, 0, 32'h300, 32'h0); access(1, 1, 0, 32'h310, 32'h6666_6666); end
        join

        // Address change mid-grant is ignored.
        lat = 5;
        exp_q.push_back(mk(0, 0, 32'h100, 32'h0));
        fork
            access(0, 0, 0, 32'h100, 32'h0);
            begin
                @(posedge clk); #3;
                repeat (3) @(negedge clk);
                p0_addr = 32'h200;
                @(negedge clk);
                chk("addr_held", mem_addr, 32'h100);
            end
        join

        // Both enables on one port: write.
        lat = 1;
        exp_q.push_back(mk(1, 1, 32'h77, 32'hABCD_0123));
        access(1, 1, 1, 32'h77, 32'hABCD_0123);

        // Reset mid-grant abandons the access.
        hold_ready = 1'b1;
        @(posedge clk); #2;
        p0_r_en = 1'b1; p0_addr = 32'h60;
        repeat (2) @(negedge clk);
        chk("pre_rst_read_en", 32'(mem_read_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_read_en", 32'(mem_read_en), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_err", 32'(err_timeout), 32'd0);
        p0_r_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_read_en", 32'(mem_read_en), 32'd0);

        // Timeout: flag rises when counter reaches 255, stays sticky.
        @(posedge clk); #2;
        p0_r_en = 1'b1; p0_addr = 32'h50;
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 255) chk("err_before_timeout", 32'(err_timeout), 32'd0);
            if (k == 256) chk("err_at_timeout", 32'(err_timeout), 32'd1);
            if (k == 300) begin
                chk("err_sticky", 32'(err_timeout), 32'd1);
                chk("still_waiting", 32'(mem_read_en), 32'd1);
            end
        end
        rst = 1'b1;
        p0_r_en = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        hold_ready = 1'b0;

        // Fixed priority: port 0 held continuously starves port 1.
        @(posedge clk); #2;
        b_p0_r_en = 1'b1; b_p0_addr = 32'h80;
        b_p1_w_en = 1'b1; b_p1_addr = 32'h90; b_p1_wdata = 32'hCAFE_F00D;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("fp_p1_blocked", 32'(b_p1_ready), 32'd0);
            if (b_p0_ready && b_mem_read_en) begin
                cnt++;
                chk("fp_p0_rdata", b_p0_rdata, model(32'h80));
            end
        end
        chk("fp_p0_grants", 32'(cnt), 32'd10);
        @(posedge clk); #2;
        b_p0_r_en = 1'b0;
        for (n = 0; n < 5; n++) begin
            @(negedge clk);
            if (b_p1_ready) break;
        end
        chk("fp_p1_served", 32'(n < 5), 32'd1);
        chk("fp_p1_addr", b_mem_addr, 32'h90);
        chk("fp_p1_wdata", b_mem_wdata, 32'hCAFE_F00D);
        @(posedge clk); #2;
        b_p1_w_en = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
